// File: rtl/regfile_mp_bypass.sv
// Multi-port integer register file: NREAD bypassed read ports, two write ports and a busy scoreboard.
// Define REGFILE_DEBUG_PORT_EN to add a raw (non-bypassed) debug read port dbg_addr/dbg_data.
module regfile_mp_bypass #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int AW    = 5,
  parameter int NREAD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr0_en,
  input  logic [AW-1:0]         wr0_addr,
  input  logic [XLEN-1:0]       wr0_data,
  input  logic                  wr1_en,
  input  logic [AW-1:0]         wr1_addr,
  input  logic [XLEN-1:0]       wr1_data,
  input  logic                  busy_set_en,
`ifdef REGFILE_DEBUG_PORT_EN
  input  logic [AW-1:0]         busy_set_addr,
  input  logic [AW-1:0]         dbg_addr,
  output logic [XLEN-1:0]       dbg_data
`else
  input  logic [AW-1:0]         busy_set_addr
`endif
);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic            wr0_live;
  logic            wr1_live;
  logic            set_live;

  // Writes to x0 are dropped everywhere; reset also suppresses the bypass so reads show 0.
  assign wr0_live = wr0_en && (wr0_addr != '0) && !rst;
  assign wr1_live = wr1_en && (wr1_addr != '0) && !rst;
  assign set_live = busy_set_en && (busy_set_addr != '0);

  // Port 1 is written last so it wins an address collision with port 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        regs[r] <= '0;
      end
    end else begin
      if (wr0_live) begin
        regs[wr0_addr] <= wr0_data;
      end
      if (wr1_live) begin
        regs[wr1_addr] <= wr1_data;
      end
    end
  end

  // A new producer issued in the same cycle as a writeback keeps the register busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wr0_live) begin
        busy[wr0_addr] <= 1'b0;
      end
      if (wr1_live) begin
        busy[wr1_addr] <= 1'b0;
      end
      if (set_live) begin
        busy[busy_set_addr] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          hit0;
    logic          hit1;

    assign a    = rd_addr[i*AW +: AW];
    assign hit0 = wr0_live && (wr0_addr == a);
    assign hit1 = wr1_live && (wr1_addr == a);

    assign rd_data[i*XLEN +: XLEN] = (a == '0) ? '0       :
                                     hit1      ? wr1_data :
                                     hit0      ? wr0_data :
                                                 regs[a];
    assign rd_busy[i] = busy[a] && !(hit0 || hit1);
  end

`ifdef REGFILE_DEBUG_PORT_EN
  assign dbg_data = regs[dbg_addr];
`endif

endmodule

// File: tb/tb_regfile_mp_bypass.sv
// Scoreboard bench for regfile_mp_bypass: directed vectors push expectations, a monitor checks at negedge.
module tb_regfile_mp_bypass;

`ifdef REGFILE_DEBUG_PORT_EN
  localparam int NR = 4;
`else
  localparam int NR = 2;
`endif

  logic            clk;
  logic            rst;
  logic [NR*5-1:0] rd_addr;
  logic [NR*32-1:0] rd_data;
  logic [NR-1:0]   rd_busy;
  logic            wr0_en;
  logic [4:0]      wr0_addr;
  logic [31:0]     wr0_data;
  logic            wr1_en;
  logic [4:0]      wr1_addr;
  logic [31:0]     wr1_data;
  logic            busy_set_en;
  logic [4:0]      busy_set_addr;
`ifdef REGFILE_DEBUG_PORT_EN
  logic [4:0]      dbg_addr;
  logic [31:0]     dbg_data;
`endif

  typedef struct {
    string       name;
    int          kind;
    int          idx;
    logic [31:0] exp;
  } exp_t;

  exp_t sbq[$];
  int   assertCount = 0;
  int   failCount   = 0;

  regfile_mp_bypass #(
    .XLEN(32), .NREG(32), .AW(5), .NREAD(NR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_busy(rd_busy),
    .wr0_en(wr0_en),
    .wr0_addr(wr0_addr),
    .wr0_data(wr0_data),
    .wr1_en(wr1_en),
    .wr1_addr(wr1_addr),
    .wr1_data(wr1_data),
    .busy_set_en(busy_set_en),
`ifdef REGFILE_DEBUG_PORT_EN
    .busy_set_addr(busy_set_addr),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
`else
    .busy_set_addr(busy_set_addr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expectData(input string name, input int port, input logic [31:0] v);
    exp_t e;
    e.name = name; e.kind = 0; e.idx = port; e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic expectBusy(input string name, input int port, input logic v);
    exp_t e;
    e.name = name; e.kind = 1; e.idx = port; e.exp = {31'b0, v};
    sbq.push_back(e);
  endtask

  task automatic expectDbg(input string name, input logic [31:0] v);
    exp_t e;
    e.name = name; e.kind = 2; e.idx = 0; e.exp = v;
    sbq.push_back(e);
  endtask

  // Even read ports get ra0, odd ports get ra1.
  task automatic applyStimulus(input logic [4:0] ra0, input logic [4:0] ra1,
                               input logic w0e, input logic [4:0] w0a, input logic [31:0] w0d,
                               input logic w1e, input logic [4:0] w1a, input logic [31:0] w1d,
                               input logic bse, input logic [4:0] bsa);
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      rd_addr[i*5 +: 5] = (i % 2 == 0) ? ra0 : ra1;
    end
    wr0_en = w0e; wr0_addr = w0a; wr0_data = w0d;
    wr1_en = w1e; wr1_addr = w1a; wr1_data = w1d;
    busy_set_en = bse; busy_set_addr = bsa;
  endtask

  task automatic checkOutput(input exp_t e);
    logic [31:0] act;
    act = '0;
    case (e.kind)
      0: act = rd_data[e.idx*32 +: 32];
      1: act = {31'b0, rd_busy[e.idx]};
`ifdef REGFILE_DEBUG_PORT_EN
      2: act = dbg_data;
`endif
      default: act = 32'hxxxx_xxxx;
    endcase
    assertCount++;
    if (act !== e.exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", e.name, act, e.exp);
    end
  endtask

  // Monitor: drain every expectation issued for the current cycle, away from the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        checkOutput(sbq.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    busy_set_en = 1'b0; busy_set_addr = '0;
`ifdef REGFILE_DEBUG_PORT_EN
    dbg_addr = 5'd5;
`endif

    // Reset held, then released between edges.
    applyStimulus(5, 31, 0, 0, 0, 0, 0, 0, 0, 0);
    expectData("rst_held_rd0", 0, 32'h0);
    expectData("rst_held_rd1", 1, 32'h0);
    expectBusy("rst_held_busy0", 0, 1'b0);
`ifdef REGFILE_DEBUG_PORT_EN
    expectDbg("rst_held_dbg", 32'h0);
`endif
    @(negedge clk);
    #2 rst = 1'b0;

    applyStimulus(5, 31, 0, 0, 0, 0, 0, 0, 0, 0);
    expectData("post_rst_rd0", 0, 32'h0);
    expectBusy("post_rst_busy1", 1, 1'b0);

    // Store x5 and mark x6 busy, then reset asynchronously mid-cycle.
    applyStimulus(5, 6, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 6);
    expectData("x5_bypass", 0, 32'hDEADBEEF);
    expectBusy("x6_set_same_cycle", 1, 1'b0);
    applyStimulus(5, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    expectData("x5_stored", 0, 32'hDEADBEEF);
    expectBusy("x6_busy", 1, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    expectData("x5_after_async_rst", 0, 32'h0);
    expectBusy("x6_after_async_rst", 1, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    applyStimulus(5, 6, 0, 0, 0, 0, 0, 0, 0, 0);
    expectData("x5_after_release", 0, 32'h0);
    expectBusy("x6_after_release", 1, 1'b0);

    // x0 immunity.
    applyStimulus(0, 0, 1, 0, 32'h1234, 0, 0, 0, 1, 0);
    expectData("x0_write_same", 0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    expectData("x0_write_next", 1, 32'h0);
    expectBusy("x0_never_busy", 0, 1'b0);

    // Write-through and persistence.
    applyStimulus(7, 3, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
    expectData("x7_write_through", 0, 32'hA5A5A5A5);
    expectData("x3_untouched", 1, 32'h0);
    applyStimulus(7, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    expectData("x7_stored", 0, 32'hA5A5A5A5);

    // Dual-write conflict, then a different-address pair.
    applyStimulus(3, 4, 1, 3, 32'h11, 1, 3, 32'h22, 0, 0);
    expectData("conflict_bypass", 0, 32'h22);
    expectData("conflict_x4", 1, 32'h0);
    applyStimulus(3, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    expectData("conflict_stored", 0, 32'h22);
    applyStimulus(3, 4, 1, 3, 32'h33, 1, 4, 32'h44, 0, 0);
    expectData("pair_bypass_x3", 0, 32'h33);
    expectData("pair_bypass_x4", 1, 32'h44);
    applyStimulus(3, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    expectData("pair_stored_x3", 0, 32'h33);
    expectData("pair_stored_x4", 1, 32'h44);

    // Scoreboard set, clear and set/write collision.
    applyStimulus(9, 9, 0, 0, 0, 0, 0, 0, 1, 9);
    expectBusy("x9_set_same_cycle", 0, 1'b0);
    applyStimulus(9, 10, 0, 0, 0, 0, 0, 0, 0, 0);
    expectBusy("x9_busy", 0, 1'b1);
    expectBusy("x10_not_busy", 1, 1'b0);
    applyStimulus(9, 9, 0, 0, 0, 1, 9, 32'h99, 0, 0);
    expectData("x9_wr1_bypass", 0, 32'h99);
    expectBusy("x9_wr1_ready", 1, 1'b0);
    applyStimulus(9, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    expectBusy("x9_cleared", 0, 1'b0);
    applyStimulus(9, 9, 1, 9, 32'h77, 0, 0, 0, 1, 9);
    expectData("x9_collide_data", 0, 32'h77);
    expectBusy("x9_collide_ready", 1, 1'b0);
    applyStimulus(9, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    expectBusy("x9_collide_set_wins", 0, 1'b1);
    expectData("x9_collide_stored", 1, 32'h77);
    applyStimulus(9, 9, 1, 9, 32'h78, 0, 0, 0, 0, 0);
    expectBusy("x9_wr0_ready", 0, 1'b0);
    applyStimulus(9, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    expectBusy("x9_wr0_cleared", 1, 1'b0);
    expectData("x9_wr0_stored", 0, 32'h78);

`ifdef REGFILE_DEBUG_PORT_EN
    // Debug port shows raw storage; all four read ports see the bypassed value.
    dbg_addr = 5'd2;
    applyStimulus(2, 2, 1, 2, 32'h1111, 0, 0, 0, 0, 0);
    expectDbg("dbg_x2_before_first", 32'h0);
    applyStimulus(2, 2, 1, 2, 32'h2222, 0, 0, 0, 0, 0);
    expectDbg("dbg_x2_old", 32'h1111);
    for (int p = 0; p < NR; p++) begin
      expectData($sformatf("x2_bypass_port%0d", p), p, 32'h2222);
    end
    applyStimulus(2, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    expectDbg("dbg_x2_new", 32'h2222);
    #1 dbg_addr = 5'd0;
    expectDbg("dbg_x0", 32'h0);
`endif

    @(posedge clk);
    @(posedge clk);
    if (sbq.size() != 0) begin
      assertCount++;
      failCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
